acc_share_arbiter: RTL
======================

Name: acc_share_arbiter

Overview:
- Shares the single 32-bit accumulator datapath between NUM_REQ independent requesters, such as Lua-driven HSE agents or RTL producers.
- Round-robin arbitration with a per-winner burst limit.
- Presents one registered valid/value pair per cycle to the accumulator-update logic and owns the accumulator register itself.
- Adds a clear command, a sticky overflow flag and per-grant tagging so software can attribute each accumulation.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, width of values and of the accumulator.
- MAX_BURST, 4, maximum consecutive grants to one requester while any other requester is valid (1..15).

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester valid.
- req_value  input  NUM_REQ*DATA_W  per-requester value; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot grant, combinational from current state and req_valid.
- clear  input  1  zero the accumulator and the overflow flag.
- acc_valid  output  1  registered; an accumulation was applied this cycle.
- acc_value  output  DATA_W  registered; the value applied.
- acc_grant_id  output  $clog2(NUM_REQ)  registered; the requester whose value was applied.
- accumulator  output  DATA_W  accumulator register.
- overflow  output  1  sticky carry-out of any accumulation since the last clear/reset.

Behaviour:
- Reset values: req_ready=0, acc_valid=0, acc_value=0, acc_grant_id=0, accumulator=0, overflow=0, rr_ptr=0, burst_cnt=0, state=IDLE.
- Transfer rule: a transfer occurs for i when req_valid[i] && req_ready[i]. At most one req_ready bit is set per cycle, and a bit is only set when that requester is valid.
- Arbitration: search begins at rr_ptr and proceeds upward with wrap-around. The first valid requester wins.
- Burst: if the previous-cycle winner w is still valid, it is re-granted unless both hold:
  - burst_cnt == MAX_BURST-1;
  - another requester is valid.
  In that case the search starts at w+1.
- burst_cnt increments on a same-winner re-grant and resets to 0 on a winner change. On a winner change, rr_ptr = winner+1 mod NUM_REQ.
- FSM states:
  - IDLE: no valid requests. Go to BUSY when any req_valid and not clear.
  - BUSY: grant every cycle. Return to IDLE when no req_valid.
  - CLEAR: entered from any state when clear=1. Lasts exactly one cycle; req_ready=0 during it. Exit to BUSY if any req_valid, else IDLE.
- Clear cycle effects: accumulator<=0 and overflow<=0 on the posedge ending the cycle in which clear=1. No transfer occurs in that cycle (req_ready forced 0), so clear wins over simultaneous requests. rr_ptr and burst_cnt are kept.
- Datapath latency:
  - Transfer in cycle N → acc_valid=1, acc_value, acc_grant_id visible in cycle N+1.
  - accumulator updated at the posedge ending cycle N+1, i.e. accumulator <= accumulator + acc_value when acc_valid.
  - Sustained throughput is one accumulation per cycle.
- Arithmetic: the addition is modulo 2^DATA_W. The carry out sets overflow, which stays 1 until clear or reset.
- Clear vs pending update: if clear=1 in the same cycle acc_valid=1, the clear wins. The accumulator goes to 0 and that pending value is discarded, not added.
- Reset mid-operation: all state returns to reset values on the next posedge. In-flight acc_valid is dropped.

Optional Feature:
- Macro: ACC_SHARE_ARBITER_STATS_EN.
- When defined:
  - Adds output port grant_count, NUM_REQ*32 bits: per-requester 32-bit transfer counters.
  - Each counter increments on its requester's transfer and saturates at 0xFFFFFFFF.
  - Counters zero on reset and on clear.
- When undefined: the port and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Single requester: req_valid=4'b0001, value=5 for 3 cycles → acc_valid in cycles 2-4, acc_grant_id=0, accumulator=15 after cycle 4.
- Fair burst: all 4 requesters valid continuously, MAX_BURST=4 → grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0…; no requester is granted more than 4 consecutive cycles.
- Wrap/overflow: accumulator=0xFFFFFFF0, then a transfer of 0x20 → accumulator=0x00000010, overflow=1. A further transfer of 1 → overflow stays 1.
- Clear collision: clear=1 while requester 2 is valid and acc_valid=1 with value 7 → req_ready=0 that cycle, accumulator=0, overflow=0, and the 7 is not added. Requester 2 is granted the following cycle.
- Reset mid-burst: assert reset for 1 cycle during a sustained 3-requester stream → all outputs read reset values next cycle, and the first grant after reset goes to requester 0.
- STATS_EN: 10 transfers from requester 1 and 3 from requester 3 → grant_count slice1=10, slice3=3. After a clear, all slices read 0.

Source files
------------

// File: rtl/acc_share_arbiter.sv
// acc_share_arbiter: round-robin arbiter with a per-winner burst limit.
// It shares one DATA_W-bit accumulator between NUM_REQ requesters.
// A granted value is registered (acc_valid/acc_value/acc_grant_id) and then
// added into the accumulator on the following edge. The accumulator has a
// sticky overflow flag and a one-cycle clear command.
// Optional feature: define ACC_SHARE_ARBITER_STATS_EN to add per-requester
// saturating 32-bit transfer counters on port grant_count.
module acc_share_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]     req_value,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          clear,
   output logic                          acc_valid,
   output logic [DATA_W-1:0]             acc_value,
   output logic [$clog2(NUM_REQ)-1:0]    acc_grant_id,
   output logic [DATA_W-1:0]             accumulator,
   output logic                          overflow
`ifdef ACC_SHARE_ARBITER_STATS_EN
   ,
   output logic [NUM_REQ*32-1:0]         grant_count
`endif
);

   localparam int ID_W = $clog2(NUM_REQ);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_CLEAR = 2'd2;

   localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

   // Requester index arithmetic modulo NUM_REQ (NUM_REQ need not be a power of two).
   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int offs);
      int sum_v;
      sum_v = int'(base) + offs;
      if (sum_v >= NUM_REQ) begin
         sum_v = sum_v - NUM_REQ;
      end else begin
         sum_v = sum_v;
      end
      return ID_W'(sum_v);
   endfunction

   // Arbitration state
   logic [1:0]        state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [3:0]        burst_cnt_q, burst_cnt_d;
   logic [ID_W-1:0]   last_win_q, last_win_d;
   logic              have_last_q, have_last_d;

   // Datapath state
   logic              acc_valid_q;
   logic [DATA_W-1:0] acc_value_q;
   logic [ID_W-1:0]   acc_grant_id_q;
   logic [DATA_W-1:0] accumulator_q;
   logic              overflow_q;

   // Combinational helpers
   logic [1:0]         cur_state_s;
   logic               any_valid_s;
   logic [NUM_REQ-1:0] others_s;
   logic               last_vld_s;
   logic               hold_s;
   logic [ID_W-1:0]    start_s;
   logic [ID_W-1:0]    cand_s;
   logic [ID_W-1:0]    win_s;
   logic               found_s;
   logic               grant_en_s;
   logic               same_s;
   logic [DATA_W-1:0]  sel_value_s;
   logic [DATA_W:0]    sum_s;

   // The CLEAR phase is exactly the cycle in which clear is high; it never outlives that cycle.
   always_comb begin
      any_valid_s = |req_valid;
      if (clear) begin
         cur_state_s = ST_CLEAR;
      end else begin
         cur_state_s = state_q;
      end
      state_d = ST_IDLE;
      case (cur_state_s)
         ST_IDLE: begin
            if (any_valid_s) begin
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (any_valid_s) begin
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (any_valid_s) begin
               state_d = ST_BUSY;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Pick the winner: hold the last winner within its burst, else round-robin search.
   always_comb begin
      others_s             = req_valid;
      others_s[last_win_q] = 1'b0;
      last_vld_s = have_last_q & req_valid[last_win_q];
      hold_s     = last_vld_s & ~((burst_cnt_q == BURST_LAST) & (|others_s));
      if (last_vld_s) begin
         start_s = wrap_add(last_win_q, 1);
      end else begin
         start_s = rr_ptr_q;
      end
      found_s = 1'b0;
      win_s   = '0;
      cand_s  = '0;
      if (hold_s) begin
         found_s = 1'b1;
         win_s   = last_win_q;
      end else begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = wrap_add(start_s, k);
            if (!found_s && req_valid[cand_s]) begin
               found_s = 1'b1;
               win_s   = cand_s;
            end else begin
               found_s = found_s;
            end
         end
      end
      grant_en_s = found_s & ~reset & (cur_state_s != ST_CLEAR);
      same_s     = have_last_q & (win_s == last_win_q);
   end

   // One-hot grant and the selected requester value.
   always_comb begin
      req_ready   = '0;
      sel_value_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_s == ID_W'(i)) begin
            req_ready[i] = grant_en_s;
            sel_value_s  = req_value[i*DATA_W +: DATA_W];
         end else begin
            req_ready[i] = 1'b0;
         end
      end
   end

   // Next round-robin pointer and burst counter on each transfer.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      last_win_d  = last_win_q;
      have_last_d = have_last_q;
      if (grant_en_s) begin
         last_win_d  = win_s;
         have_last_d = 1'b1;
         if (same_s) begin
            if (burst_cnt_q == BURST_LAST) begin
               burst_cnt_d = burst_cnt_q;
            end else begin
               burst_cnt_d = burst_cnt_q + 4'd1;
            end
         end else begin
            burst_cnt_d = 4'd0;
            rr_ptr_d    = wrap_add(win_s, 1);
         end
      end else begin
         have_last_d = have_last_q;
      end
   end

   // Arbitration and FSM registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         burst_cnt_q <= 4'd0;
         last_win_q  <= '0;
         have_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         last_win_q  <= last_win_d;
         have_last_q <= have_last_d;
      end
   end

   // Full-width sum; the top bit is the carry-out that feeds the overflow flag.
   always_comb begin
      sum_s = {1'b0, accumulator_q} + {1'b0, acc_value_q};
   end

   // Register the granted value, then fold it into the accumulator; clear discards a pending value.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc_valid_q    <= 1'b0;
         acc_value_q    <= '0;
         acc_grant_id_q <= '0;
         accumulator_q  <= '0;
         overflow_q     <= 1'b0;
      end else begin
         acc_valid_q <= grant_en_s;
         if (grant_en_s) begin
            acc_value_q    <= sel_value_s;
            acc_grant_id_q <= win_s;
         end
         if (clear) begin
            accumulator_q <= '0;
            overflow_q    <= 1'b0;
         end else if (acc_valid_q) begin
            accumulator_q <= sum_s[DATA_W-1:0];
            overflow_q    <= overflow_q | sum_s[DATA_W];
         end
      end
   end

   assign acc_valid    = acc_valid_q;
   assign acc_value    = acc_value_q;
   assign acc_grant_id = acc_grant_id_q;
   assign accumulator  = accumulator_q;
   assign overflow     = overflow_q;

`ifdef ACC_SHARE_ARBITER_STATS_EN
   logic [31:0] cnt_q [NUM_REQ];

   // Per-requester saturating transfer counters, zeroed by reset and clear.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (reset || clear) begin
            cnt_q[i] <= 32'd0;
         end else if (req_ready[i] && req_valid[i] && (cnt_q[i] != 32'hFFFF_FFFF)) begin
            cnt_q[i] <= cnt_q[i] + 32'd1;
         end
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
      assign grant_count[g*32 +: 32] = cnt_q[g];
   end
`endif

endmodule
